// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Shared constants for the integer datapath. Holds the ALU op
//            codes, the M-extension op codes (funct3 encoding) and the
//            muldiv_unit FSM states. It also holds small helpers that decode
//            operand signedness.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // Base ALU op codes used by the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // M-extension ops, encoded exactly as funct3
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam int CNT_W = 6;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : One combinational step of the iterative multiplier/divider.
//            Multiply: acc = {hi, multiplier}. The step conditionally adds the
//            operand into hi and then shifts {carry, hi, lo} right by one.
//            Divide (restoring): acc = {remainder, dividend/quotient}. The
//            step shifts left, trial-subtracts the divisor from the 33-bit
//            partial remainder, and shifts in the quotient bit.
// Ports    : is_div  - select divide step (else multiply step)
//            acc_in  - 2*XLEN accumulator before the step
//            operand - multiplicand or divisor magnitude
//            acc_out - 2*XLEN accumulator after the step
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]   w_add_sum;
    logic [XLEN:0]   w_shifted;
    logic            w_fits;
    logic [XLEN-1:0] w_diff;

    // Multiply: carry out of the add becomes the new MSB after the shift
    assign w_add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]}
                     + (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});

    // Divide: 33-bit partial remainder after pulling in the next dividend bit
    assign w_shifted = acc_in[2*XLEN-1:XLEN-1];
    assign w_fits    = (w_shifted >= {1'b0, operand});
    // When the divisor fits, the difference is below the divisor, so the low
    // XLEN bits hold it exactly
    assign w_diff    = w_shifted[XLEN-1:0] - operand;

    always_comb begin
        if (is_div) begin
            if (w_fits) begin
                acc_out = {w_diff, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {w_shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {w_add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//            REM/REMU). It runs one shift-add or restoring shift-subtract step
//            per cycle on operand magnitudes and applies signs when it enters
//            DONE. Divide-by-zero and signed overflow bypass CALC.
// Ports    : clk, rst_n (sync, active-low)
//            start, op, a, b, rd_addr_in - op request from execute stage
//            flush                        - abort in-flight op
//            stall_req, busy              - pipeline hold / unit occupied
//            done, result, rd_addr_out    - registered completion
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    muldiv_op_e        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              done_q, done_d;

    muldiv_op_e        w_op;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div0, w_ovf;
    logic [2*XLEN-1:0] w_acc_iter;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s, w_rem_s;

    assign w_op    = muldiv_op_e'(op);
    assign w_a_neg = op_signed_a(w_op) & a[XLEN-1];
    assign w_b_neg = op_signed_b(w_op) & b[XLEN-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_div0  = op_is_div(w_op) && (b == '0);
    assign w_ovf   = (w_op == OP_DIV || w_op == OP_REM) && (a == INT_MIN) && (b == '1);

    muldiv_iter #(
        .XLEN    (XLEN)
    ) u_iter (
        .is_div  (op_is_div(op_q)),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (w_acc_iter)
    );

    // Sign fix-up applied to the accumulator value produced by the final step.
    // For unsigned ops the latched sign flags are zero.
    assign w_prod_s = (a_neg_q ^ b_neg_q) ? -w_acc_iter : w_acc_iter;
    assign w_quo_s  = (a_neg_q ^ b_neg_q) ? -w_acc_iter[XLEN-1:0] : w_acc_iter[XLEN-1:0];
    assign w_rem_s  = a_neg_q ? -w_acc_iter[2*XLEN-1:XLEN] : w_acc_iter[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = w_op;
                    a_neg_d = w_a_neg;
                    b_neg_d = w_b_neg;
                    rd_d    = rd_addr_in;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, w_a_mag};
                    opnd_d  = w_b_mag;
                    if (w_div0 || w_ovf) begin
                        // Architecturally defined corner results need no iteration
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        rd_out_d = rd_addr_in;
                        if (w_div0) begin
                            result_d = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : a;
                        end else begin
                            result_d = (w_op == OP_DIV) ? INT_MIN : '0;
                        end
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = w_acc_iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    rd_out_d = rd_q;
                    case (op_q)
                        OP_MUL:                       result_d = w_prod_s[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = w_prod_s[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU:              result_d = w_quo_s;
                        default:                      result_d = w_rem_s;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush wins over everything, including a same-cycle start or completion
        if (flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= OP_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign stall_req   = ((state_q == ST_IDLE) && start) || (state_q == ST_CALC);
    assign done        = done_q;
    assign result      = result_q;
    assign rd_addr_out = rd_out_q;

endmodule
`default_nettype wire
